// File: rtl/fsk_pkg.sv
// Shared types and default sizes for the FSK phase-increment generator.
package fsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SYM  = 1'b1
  } fsk_state_e;

  localparam int PHI_W_DEF     = 32;
  localparam int LEN_W_DEF     = 16;
  localparam int RAMP_LOG2_DEF = 3;

endpackage

// File: rtl/fsk_inc_ramp.sv
// Linear ramp of the phase increment toward a new target in 2^RAMP_LOG2 enabled cycles.
// Compiled only when FSK_RAMP_EN is defined; RAMP_LOG2 must be at least 1.
`ifdef FSK_RAMP_EN
module fsk_inc_ramp #(
  parameter int PHI_W     = 32,
  parameter int RAMP_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic             load,
  input  logic             follow,
  input  logic [PHI_W-1:0] tgt,
  output logic [PHI_W-1:0] phi_o
);

  logic signed [PHI_W-1:0] diff;
  logic signed [PHI_W-1:0] step_new;
  logic signed [PHI_W-1:0] step_q;
  logic        [PHI_W-1:0] target_q;
  logic [RAMP_LOG2-1:0]    rcnt;
  logic                    active;

  function automatic logic signed [PHI_W-1:0] ramp_step(input logic signed [PHI_W-1:0] d);
    return d >>> RAMP_LOG2;
  endfunction

  assign diff     = signed'(tgt - phi_o);
  assign step_new = ramp_step(diff);

  // The accepting edge already applies the first step; the final edge snaps to the exact target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_o  <= '0;
      rcnt   <= '0;
      active <= 1'b0;
    end else if (clken) begin
      if (load) begin
        if (tgt != phi_o) begin
          phi_o  <= phi_o + step_new;
          rcnt   <= RAMP_LOG2'(1);
          active <= 1'b1;
        end else begin
          active <= 1'b0;
        end
      end else if (active) begin
        if (rcnt == '1) begin
          phi_o  <= target_q;
          active <= 1'b0;
        end else begin
          phi_o <= phi_o + step_q;
          rcnt  <= rcnt + RAMP_LOG2'(1);
        end
      end else if (follow) begin
        phi_o <= tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clken && load) begin
      target_q <= tgt;
      step_q   <= step_new;
    end
  end

endmodule
`endif

// File: rtl/fsk_phase_inc_gen.sv
// Binary FSK front-end: turns handshaked bits into a held phase-increment word for the NCO.
// Optional FSK_RAMP_EN replaces the hard frequency step with a linear ramp (fsk_inc_ramp).
module fsk_phase_inc_gen
  import fsk_pkg::*;
#(
  parameter int PHI_W     = PHI_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int RAMP_LOG2 = RAMP_LOG2_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clken,
  input  logic [PHI_W-1:0] f0_inc_i,
  input  logic [PHI_W-1:0] f1_inc_i,
  input  logic [LEN_W-1:0] sym_len_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  output logic [PHI_W-1:0] phi_inc_o,
  output logic             sym_strobe_o,
  output logic             busy_o
);

  fsk_state_e       state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_m1, len_nxt;
  logic             armed;
  logic             accept;
  logic             go_idle;
  logic [PHI_W-1:0] sel_inc;

  // armed keeps bit_ready_o low until the first enabled cycle after reset.
  assign bit_ready_o = armed & ((state == IDLE) | (cnt == len_m1));
  assign accept      = clken & bit_valid_i & bit_ready_o;
  assign busy_o      = (state == SYM);
  assign sel_inc     = bit_i ? f1_inc_i : f0_inc_i;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len_m1;
    go_idle   = 1'b0;
    if (accept) begin
      state_nxt = SYM;
      cnt_nxt   = '0;
      len_nxt   = (sym_len_i == '0) ? '0 : sym_len_i - LEN_W'(1);
    end else if (clken && state == SYM) begin
      if (cnt == len_m1) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        go_idle   = 1'b1;
      end else begin
        cnt_nxt = cnt + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      len_m1       <= '0;
      armed        <= 1'b0;
      sym_strobe_o <= 1'b0;
    end else begin
      sym_strobe_o <= accept;
      if (clken) begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        len_m1 <= len_nxt;
        armed  <= 1'b1;
      end
    end
  end

`ifdef FSK_RAMP_EN
  fsk_inc_ramp #(
    .PHI_W     (PHI_W),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_ramp (
    .clk     (clk),
    .reset_n (reset_n),
    .clken   (clken),
    .load    (accept | go_idle),
    .follow  (state == IDLE),
    .tgt     (accept ? sel_inc : f0_inc_i),
    .phi_o   (phi_inc_o)
  );
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = go_idle & (RAMP_LOG2 != 0);

  // Increment is latched at accept, so mid-symbol config changes wait for the next symbol.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi_inc_o <= '0;
    end else if (clken) begin
      if (accept) begin
        phi_inc_o <= sel_inc;
      end else if (state_nxt == IDLE) begin
        phi_inc_o <= f0_inc_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fsk_phase_inc_gen.sv
// Directed bench for fsk_phase_inc_gen (default build, hard frequency steps).
module tb_fsk_phase_inc_gen;

  localparam logic [31:0] F0 = 32'h1000_0000;
  localparam logic [31:0] F1 = 32'h2000_0000;
  localparam logic [31:0] F0B = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken;
  logic [31:0] f0_inc_i;
  logic [31:0] f1_inc_i;
  logic [15:0] sym_len_i;
  logic        bit_i;
  logic        bit_valid_i;
  logic        bit_ready_o;
  logic [31:0] phi_inc_o;
  logic        sym_strobe_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  fsk_phase_inc_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clken        (clken),
    .f0_inc_i     (f0_inc_i),
    .f1_inc_i     (f1_inc_i),
    .sym_len_i    (sym_len_i),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .bit_ready_o  (bit_ready_o),
    .phi_inc_o    (phi_inc_o),
    .sym_strobe_o (sym_strobe_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] phi, input logic rdy,
                         input logic stb, input logic bsy);
    chk({tag, ".phi"}, phi_inc_o, phi);
    chk({tag, ".rdy"}, 32'(bit_ready_o), 32'(rdy));
    chk({tag, ".stb"}, 32'(sym_strobe_o), 32'(stb));
    chk({tag, ".busy"}, 32'(busy_o), 32'(bsy));
  endtask

  initial begin
    logic [3:0] pat;
    reset_n     = 1'b0;
    clken       = 1'b1;
    f0_inc_i    = F0;
    f1_inc_i    = F1;
    sym_len_i   = 16'd4;
    bit_i       = 1'b0;
    bit_valid_i = 1'b0;

    // Reset state, then the first enabled edge loads f0 and raises ready.
    tick();
    tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_all("idle0", F0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("idle1", F0, 1'b1, 1'b0, 1'b0);

    // Bits 1,0,1 back-to-back with L = 4.
    pat = 4'b0101;
    bit_i       = 1'b1;
    bit_valid_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_all($sformatf("l4.s%0d.c%0d", s, c), (bit_i ? F1 : F0), (c == 3), (c == 0), 1'b1);
        if (c == 3) begin
          if (s == 2) bit_valid_i = 1'b0;
          else        bit_i = pat[s + 1];
        end
      end
    end
    tick();
    chk_all("l4.idle", F0, 1'b1, 1'b0, 1'b0);

    // L = 0 and L = 1: one-cycle symbols, ready stays high.
    for (int l = 0; l < 2; l++) begin
      sym_len_i   = 16'(l);
      bit_valid_i = 1'b1;
      for (int b = 0; b < 4; b++) begin
        bit_i = (b % 2 == 0);
        tick();
        chk_all($sformatf("l%0d.b%0d", l, b), ((b % 2 == 0) ? F1 : F0), 1'b1, 1'b1, 1'b1);
      end
      bit_valid_i = 1'b0;
      tick();
      chk_all($sformatf("l%0d.idle", l), F0, 1'b1, 1'b0, 1'b0);
    end

    // L = 3 with clken toggling: symbol spans 3 enabled cycles / 6 clocks.
    sym_len_i   = 16'd3;
    bit_i       = 1'b1;
    bit_valid_i = 1'b1;
    tick();
    chk_all("ce.acc", F1, 1'b0, 1'b1, 1'b1);
    bit_valid_i = 1'b0;
    clken = 1'b0; tick(); chk_all("ce.h0", F1, 1'b0, 1'b0, 1'b1);
    clken = 1'b1; tick(); chk_all("ce.c1", F1, 1'b0, 1'b0, 1'b1);
    clken = 1'b0; tick(); chk_all("ce.h1", F1, 1'b0, 1'b0, 1'b1);
    clken = 1'b1; tick(); chk_all("ce.c2", F1, 1'b1, 1'b0, 1'b1);
    clken = 1'b0; tick(); chk_all("ce.h2", F1, 1'b1, 1'b0, 1'b1);
    clken = 1'b1; tick(); chk_all("ce.idle", F0, 1'b1, 1'b0, 1'b0);

    // Config change mid-symbol waits; in IDLE it follows after one edge.
    sym_len_i   = 16'd2;
    bit_i       = 1'b0;
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
    f0_inc_i    = F0B;
    chk_all("cfg.c0", F0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("cfg.c1", F0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("cfg.idle", F0B, 1'b1, 1'b0, 1'b0);
    f0_inc_i = F0;
    tick();
    chk_all("cfg.back", F0, 1'b1, 1'b0, 1'b0);

    // Reset at counter = 1 of a bit-1 symbol; the bit must not reappear.
    sym_len_i   = 16'd4;
    bit_i       = 1'b1;
    bit_valid_i = 1'b1;
    tick();
    bit_valid_i = 1'b0;
    tick();
    chk_all("rst.c1", F1, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_all("rst.async", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_all("rst.rel0", F0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("rst.rel1", F0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
